// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - N-to-2**N registered decoder with direct and auto-scan modes
module decoder_scan #(
  parameter int N    = 3,
  parameter bit DOWN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic              step,
  input  logic [N-1:0]      in,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  // index value from which a step wraps around
  localparam logic [N-1:0] LAST = DOWN ? {N{1'b0}} : {N{1'b1}};

  state_t         state;
  logic [N-1:0]   step_idx;

  function automatic logic [2**N-1:0] onehot(input logic [N-1:0] v);
    logic [2**N-1:0] r;
    r    = '0;
    r[v] = 1'b1;
    return r;
  endfunction

  always_comb begin
    step_idx = DOWN ? (idx - N'(1)) : (idx + N'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      state <= IDLE;
      out   <= '0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state <= DECODE;
      idx   <= in;
      out   <= onehot(in);
      wrap  <= 1'b0;
    end else if (state != SCAN) begin
      state <= SCAN;
      idx   <= in;
      out   <= onehot(in);
      wrap  <= 1'b0;
    end else if (load) begin
      idx   <= in;
      out   <= onehot(in);
      wrap  <= 1'b0;
    end else if (step) begin
      idx   <= step_idx;
      out   <= onehot(step_idx);
      wrap  <= (idx == LAST);
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed scoreboard bench for decoder_scan (N=3 up, N=3 down, N=4 up)
module tb_decoder_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic a_en, a_mode, a_load, a_step; logic [2:0] a_in; logic [7:0]  a_out; logic [2:0] a_idx; logic a_wrap;
  logic b_en, b_mode, b_load, b_step; logic [2:0] b_in; logic [7:0]  b_out; logic [2:0] b_idx; logic b_wrap;
  logic c_en, c_mode, c_load, c_step; logic [3:0] c_in; logic [15:0] c_out; logic [3:0] c_idx; logic c_wrap;

  decoder_scan #(.N(3), .DOWN(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .load(a_load),
    .step(a_step), .in(a_in), .out(a_out), .idx(a_idx), .wrap(a_wrap));
  decoder_scan #(.N(3), .DOWN(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .load(b_load),
    .step(b_step), .in(b_in), .out(b_out), .idx(b_idx), .wrap(b_wrap));
  decoder_scan #(.N(4), .DOWN(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .en(c_en), .mode(c_mode), .load(c_load),
    .step(c_step), .in(c_in), .out(c_out), .idx(c_idx), .wrap(c_wrap));

  typedef struct {
    logic [15:0] out;
    logic [3:0]  idx;
    logic        wrap;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // drive one instance for one cycle, queue its expectation, compare after the edge
  task automatic cyc(input int w, input logic e, input logic m, input logic l, input logic s,
                     input logic [3:0] v, input logic [15:0] eo, input logic [3:0] ei,
                     input logic ew, input string tag);
    exp_t x;
    logic [15:0] oo;
    logic [3:0]  oi;
    logic        ow;
    case (w)
      0: begin a_en = e; a_mode = m; a_load = l; a_step = s; a_in = v[2:0]; end
      1: begin b_en = e; b_mode = m; b_load = l; b_step = s; b_in = v[2:0]; end
      default: begin c_en = e; c_mode = m; c_load = l; c_step = s; c_in = v; end
    endcase
    x.out = eo; x.idx = ei; x.wrap = ew; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    case (w)
      0: begin oo = {8'h00, a_out}; oi = {1'b0, a_idx}; ow = a_wrap; end
      1: begin oo = {8'h00, b_out}; oi = {1'b0, b_idx}; ow = b_wrap; end
      default: begin oo = c_out; oi = c_idx; ow = c_wrap; end
    endcase
    x = sb.pop_front();
    check({x.tag, "_out"},  32'(oo), 32'(x.out));
    check({x.tag, "_idx"},  32'(oi), 32'(x.idx));
    check({x.tag, "_wrap"}, 32'(ow), 32'(x.wrap));
    check({x.tag, "_onehot"}, 32'($onehot0(oo)), 32'd1);
  endtask

  task automatic check_reset_all(input string tag);
    check({tag, "_a_out"}, 32'(a_out), 32'd0);
    check({tag, "_a_idx"}, 32'(a_idx), 32'd0);
    check({tag, "_a_wrap"}, 32'(a_wrap), 32'd0);
    check({tag, "_b_out"}, 32'(b_out), 32'd0);
    check({tag, "_c_out"}, 32'(c_out), 32'd0);
    check({tag, "_c_idx"}, 32'(c_idx), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_en = 1'b1; a_mode = 1'b0; a_load = 1'b0; a_step = 1'b0; a_in = '0;
    b_en = 1'b1; b_mode = 1'b0; b_load = 1'b0; b_step = 1'b0; b_in = '0;
    c_en = 1'b1; c_mode = 1'b0; c_load = 1'b0; c_step = 1'b0; c_in = '0;
    #3;
    check_reset_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // decode sweep, one-cycle latency
    for (int i = 0; i < 8; i++)
      cyc(0, 0, 0, 0, 0, 4'(i), 16'(1 << i), 4'(i), 0, $sformatf("sweep%0d", i));

    // disable holds idx and blanks out regardless of in
    cyc(0, 0, 0, 0, 0, 4'd5, 16'h0020, 4'd5, 0, "dec5");
    cyc(0, 1, 0, 0, 0, 4'd5, 16'h0000, 4'd5, 0, "dis5");
    cyc(0, 1, 0, 0, 0, 4'd0, 16'h0000, 4'd5, 0, "dis0");
    cyc(0, 1, 1, 1, 1, 4'd3, 16'h0000, 4'd5, 0, "dis3");
    cyc(0, 1, 0, 0, 0, 4'd7, 16'h0000, 4'd5, 0, "dis7");

    // scan entry from IDLE, then wrap
    cyc(0, 0, 1, 0, 0, 4'd6, 16'h0040, 4'd6, 0, "scan_in6");
    cyc(0, 0, 1, 0, 1, 4'd6, 16'h0080, 4'd7, 0, "step7");
    cyc(0, 0, 1, 0, 1, 4'd6, 16'h0001, 4'd0, 1, "step0_wrap");
    cyc(0, 0, 1, 0, 1, 4'd6, 16'h0002, 4'd1, 0, "step1");
    cyc(0, 0, 1, 0, 0, 4'd6, 16'h0002, 4'd1, 0, "hold1");

    // load priority and load never wraps
    cyc(0, 0, 1, 1, 0, 4'd2, 16'h0004, 4'd2, 0, "load2");
    cyc(0, 0, 1, 1, 1, 4'd5, 16'h0020, 4'd5, 0, "loadstep5");
    cyc(0, 0, 1, 1, 0, 4'd7, 16'h0080, 4'd7, 0, "load7");
    cyc(0, 0, 1, 1, 1, 4'd0, 16'h0001, 4'd0, 0, "load0_nowrap");

    // mode switches
    cyc(0, 0, 0, 0, 1, 4'd4, 16'h0010, 4'd4, 0, "to_decode4");
    cyc(0, 0, 1, 0, 1, 4'd1, 16'h0002, 4'd1, 0, "to_scan1");
    cyc(0, 0, 1, 0, 1, 4'd1, 16'h0004, 4'd2, 0, "scan_step2");

    // async reset mid-scan
    cyc(0, 0, 1, 1, 0, 4'd4, 16'h0010, 4'd4, 0, "load4");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_all("async_rst");
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 1, 0, 1, 4'd3, 16'h0008, 4'd3, 0, "post_rst3");

    // DOWN=1
    cyc(1, 0, 1, 0, 0, 4'd0, 16'h0001, 4'd0, 0, "dn_in0");
    cyc(1, 0, 1, 0, 1, 4'd0, 16'h0080, 4'd7, 1, "dn_wrap7");
    cyc(1, 0, 1, 0, 1, 4'd0, 16'h0040, 4'd6, 0, "dn_step6");
    cyc(1, 0, 1, 1, 0, 4'd0, 16'h0001, 4'd0, 0, "dn_load0");

    // N=4
    cyc(2, 0, 0, 0, 0, 4'd15, 16'h8000, 4'd15, 0, "n4_dec15");
    cyc(2, 0, 1, 0, 0, 4'd15, 16'h8000, 4'd15, 0, "n4_scan15");
    cyc(2, 0, 1, 0, 1, 4'd15, 16'h0001, 4'd0, 1, "n4_wrap0");
    cyc(2, 0, 1, 0, 1, 4'd15, 16'h0002, 4'd1, 0, "n4_step1");
    cyc(2, 1, 1, 0, 1, 4'd15, 16'h0000, 4'd1, 0, "n4_dis");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter: N, default 3, select width; output width is 2**N (N=3 gives 3-to-8).
REQ-002 Parameter: DOWN, default 0; 0 means scan increments the index, 1 means scan decrements it.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: en  input  1  enable, active-low (0 = active, 1 = disabled).
REQ-006 Port: mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 Port: load  input  1  scan-mode reload strobe; index <= in.
REQ-008 Port: step  input  1  scan-mode advance strobe.
REQ-009 Port: in  input  N  select value.
REQ-010 Port: out  output  2**N  registered one-hot output (all-zero when disabled).
REQ-011 Port: idx  output  N  registered current index.
REQ-012 Port: wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 The block SHALL implement states IDLE, DECODE and SCAN, all outputs registered.
REQ-014 In every state, out SHALL equal the one-hot of idx (bit idx set), except in IDLE, where out SHALL be all-zero.
REQ-015 en=1 SHALL move the block to IDLE on the next edge from any state, overriding mode, load and step; idx SHALL hold its value.
REQ-016 en=0, mode=0 SHALL move the block to DECODE with idx <= in each cycle; out reflects in after exactly 1 cycle of latency.
REQ-017 en=0, mode=1, entered from IDLE or DECODE, SHALL move the block to SCAN with idx <= in on the entry edge.
REQ-018 In SCAN with load=1, idx SHALL be set to in; load has priority over step.
REQ-019 In SCAN with step=1 and load=0, idx SHALL advance by +1 (DOWN=0) or -1 (DOWN=1), modulo 2**N.
REQ-020 In SCAN with load=0 and step=0, idx and out SHALL hold.
REQ-021 wrap SHALL be 1 for exactly the cycle after a step takes idx from 2**N-1 to 0 (DOWN=0) or from 0 to 2**N-1 (DOWN=1); otherwise wrap is 0.
REQ-022 A load SHALL never raise wrap, even when the loaded value equals the wrapped value.
REQ-023 A mode change 1->0 while en=0 SHALL move the block from SCAN to DECODE on the next edge, with idx <= in.
REQ-024 A mode change 0->1 while en=0 SHALL move the block from DECODE to SCAN on the next edge, with idx <= in.
REQ-025 out SHALL never have more than one bit set in any cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, out=0, idx=0 and wrap=0, independent of clk.
REQ-027 While rst_n=0, inputs SHALL be ignored; the first edge after release SHALL follow the normal rules from IDLE.
REQ-028 Reset asserted mid-scan SHALL discard the scan position; after release, scan restarts from in.

Verification
REQ-029 Decode sweep (N=3, DOWN=0): en=0, mode=0, in=0..7 one per cycle -> out=00000001..10000000, each 1 cycle after its in, idx equal to in.
REQ-030 Disable: after in=3'b101 decoded, set en=1 -> next cycle out=00000000, idx=101; apply in=000, 011, 111 -> out stays 00000000.
REQ-031 Scan wrap (N=3, DOWN=0): en=0, mode=1, in=6, then step=1 for 3 cycles -> idx 6,7,0,1; wrap=1 only in the cycle idx becomes 0.
REQ-032 Load priority: in SCAN at idx=2, load=1, step=1, in=5 -> idx=5 next cycle, wrap=0; DOWN=1 variant: from idx=0, step -> idx=7, wrap=1.
REQ-033 Async reset: during a scan at idx=4, pulse rst_n low between clock edges -> out=0, idx=0, wrap=0 immediately; after release with en=0, mode=1, in=3 -> idx=3, out=00001000.
REQ-034 Parameter N=4: decode in=15 -> out bit 15 only; scan from 15 with step -> idx=0, wrap=1; out is one-hot in every cycle.
